// File: rtl/max_pool_stream_if.sv
// Pixel-in / pooled-pixel-out stream bundle plus frame start/busy/done control
// for max_pool_stream_ctrl.
interface max_pool_stream_if #(
    parameter int unsigned DW = 13
);
    logic          start;
    logic          busy;
    logic          done;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output start, in_data, in_valid, out_ready,
        input  busy, done, in_ready, out_data, out_valid
    );

    modport slave (
        input  start, in_data, in_valid, out_ready,
        output busy, done, in_ready, out_data, out_valid
    );
endinterface

// File: rtl/max_pool_stream_ctrl.sv
// 2x2 / stride-2 streaming max pool over one IMG_W x IMG_H frame of signed pixels.
// Optional fused ReLU on the output register: define MAX_POOL_RELU_EN.
module max_pool_stream_ctrl #(
    parameter int unsigned INTEGER_BITS     = 9,
    parameter int unsigned FIXED_POINT_BITS = 4,
    parameter int unsigned IMG_W            = 28,
    parameter int unsigned IMG_H            = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    max_pool_stream_if.slave bus
);
    localparam int unsigned DW       = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int unsigned CW       = $clog2(IMG_W);
    localparam int unsigned RW       = $clog2(IMG_H);
    localparam int unsigned LB_DEPTH = IMG_W / 2;
    localparam int unsigned LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] pair_q, pair_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic [DW-1:0]  line_buf [LB_DEPTH];
    logic [LBW-1:0] lb_idx;
    logic           lb_we;
    logic [DW-1:0]  lb_rd;
    logic [DW-1:0]  pair_max;
    logic [DW-1:0]  win_max;
    logic [DW-1:0]  pooled;
    logic           in_ready_c;
    logic           accept;

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign lb_idx   = LBW'(col_q >> 1);
    assign lb_rd    = line_buf[lb_idx];
    assign pair_max = smax(pair_q, bus.in_data);
    assign win_max  = smax(pair_max, lb_rd);

`ifdef MAX_POOL_RELU_EN
    assign pooled = win_max[DW-1] ? '0 : win_max;
`else
    assign pooled = win_max;
`endif

    // Stall input whenever a pooled pixel is waiting and not being taken this cycle.
    assign in_ready_c = busy_q & (state_q != FLUSH) & ~(out_valid_q & ~bus.out_ready);
    assign accept     = bus.in_valid & in_ready_c;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        lb_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = EVEN_ROW;
                    busy_d  = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            EVEN_ROW, ODD_ROW: begin
                if (accept) begin
                    if (!col_q[0]) begin
                        pair_d = bus.in_data;
                    end else if (state_q == EVEN_ROW) begin
                        lb_we = 1'b1;
                    end else begin
                        out_data_d  = pooled;
                        out_valid_d = 1'b1;
                    end

                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(IMG_H - 1)) begin
                            row_d   = '0;
                            state_d = FLUSH;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (!out_valid_q || bus.out_ready) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= MIN_VAL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Even-row pair maxima; contents are rewritten before every read, so no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_idx] <= pair_max;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_max_pool_stream_ctrl.sv
// Randomized bench for max_pool_stream_ctrl on a 4x4 frame, checked against a
// window-max reference model computed directly from each frame's pixel array.
module tb_max_pool_stream_ctrl;
    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;
    localparam int unsigned DW   = 13;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned NOUT = (W / 2) * (H / 2);

    typedef logic [DW-1:0] frame_t [NPIX];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    max_pool_stream_if #(.DW(DW)) bus ();

    max_pool_stream_ctrl #(
        .INTEGER_BITS    (9),
        .FIXED_POINT_BITS(4),
        .IMG_W           (W),
        .IMG_H           (H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_e;
    logic [DW-1:0] held_data;
    bit  held = 0;
    bit  lat_pend = 0;
    bit  seen_valid = 0;
    int  done_cnt = 0;
    int  pix_idx = 0;
    int  rdy_mode = 0;
    int  stall_left = 0;
    int  stall_cycles = 0;

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Reference: signed max over the 2x2 window, optional ReLU.
    function automatic logic [DW-1:0] pool(input frame_t px, input int wr, input int wc);
        int m;
        int v;
        m = -(1 << (DW - 1));
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = int'($signed(px[(2 * wr + dr) * W + 2 * wc + dc]));
                if (v > m) m = v;
            end
        end
`ifdef MAX_POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return DW'(m);
    endfunction

    function automatic logic [DW-1:0] rand_pix();
        case ($urandom_range(0, 3))
            0:       return DW'($urandom);
            1:       return {1'b1, {(DW-1){1'b0}}};
            2:       return DW'($urandom_range(0, 2));
            default: return {1'b0, {(DW-1){1'b1}}};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output-side sink
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            step();
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (!seen_valid) begin
                        bus.out_ready = 1'b0;
                        if (bus.out_valid) begin
                            seen_valid = 1'b1;
                            stall_left = 9;
                        end
                    end else if (stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Compare process: scoreboard, hold/stall rules, latency, done.
    always @(negedge clk) begin
        if (!rst_n) begin
            held     = 1'b0;
            lat_pend = 1'b0;
        end else begin
            if (lat_pend) chk(bus.out_valid == 1'b1, "out_latency", 32'(bus.out_valid), 1);
            lat_pend = 1'b0;
            if (bus.out_valid) begin
                if (held) chk(bus.out_data == held_data, "out_hold", 32'(bus.out_data), 32'(held_data));
                if (!bus.out_ready) begin
                    chk(bus.in_ready == 1'b0, "stall_in_ready", 32'(bus.in_ready), 0);
                    held      = 1'b1;
                    held_data = bus.out_data;
                    stall_cycles++;
                end else begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_out", 32'(bus.out_data), 0);
                    end else begin
                        exp_e = exp_q.pop_front();
                        chk(bus.out_data == exp_e, "out_data", 32'(bus.out_data), 32'(exp_e));
                        got_q.push_back(bus.out_data);
                    end
                end
            end else begin
                held = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (((pix_idx / W) % 2 == 1) && ((pix_idx % W) % 2 == 1)) lat_pend = 1'b1;
                pix_idx++;
            end
            if (bus.done) begin
                done_cnt++;
                chk(exp_q.size() == 0, "done_outs_left", 32'(exp_q.size()), 0);
            end
        end
    end

    task automatic send_pixel(input logic [DW-1:0] d, input int gap, output int waits);
        bit acc;
        waits = 0;
        repeat (gap) step();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            if (acc) break;
            waits++;
            if (waits > 200) begin
                chk(1'b0, "accept_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = DW'($urandom);
    endtask

    task automatic start_frame(input frame_t px, input int mode);
        rdy_mode     = mode;
        seen_valid   = 1'b0;
        stall_cycles = 0;
        got_q.delete();
        for (int wr = 0; wr < int'(H / 2); wr++)
            for (int wc = 0; wc < int'(W / 2); wc++)
                exp_q.push_back(pool(px, wr, wc));
        pix_idx  = 0;
        done_cnt = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk(bus.busy == 1'b1, "busy_after_start", 32'(bus.busy), 1);
    endtask

    task automatic run_frame(input frame_t px, input int gap_max, input int mode,
                             input int restart_at, input bit full_rate);
        int waits;
        int n;
        start_frame(px, mode);
        for (int i = 0; i < int'(NPIX); i++) begin
            if (restart_at == i) begin
                bus.start = 1'b1;
                step();
                bus.start = 1'b0;
                chk(bus.busy == 1'b1, "busy_on_restart", 32'(bus.busy), 1);
            end
            send_pixel(px[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, waits);
            if (full_rate) chk(waits == 0, "in_ready_drop", 32'(waits), 0);
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.done) break;
            n++;
            if (n > 500) begin
                chk(1'b0, "done_timeout", 0, 1);
                break;
            end
        end
        chk(bus.busy == 1'b0, "busy_at_done", 32'(bus.busy), 0);
        step();
        step();
        chk(bus.done == 1'b0, "done_pulse_width", 32'(bus.done), 0);
        chk(bus.in_ready == 1'b0, "idle_in_ready", 32'(bus.in_ready), 0);
        chk(done_cnt == 1, "done_count", 32'(done_cnt), 1);
        chk(got_q.size() == NOUT, "out_count", 32'(got_q.size()), NOUT);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk(bus.busy == 1'b0,      {tag, "_busy"},      32'(bus.busy), 0);
        chk(bus.done == 1'b0,      {tag, "_done"},      32'(bus.done), 0);
        chk(bus.in_ready == 1'b0,  {tag, "_in_ready"},  32'(bus.in_ready), 0);
        chk(bus.out_valid == 1'b0, {tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk(bus.out_data == '0,    {tag, "_out_data"},  32'(bus.out_data), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t px;
        logic [DW-1:0] lit_a [4];
        logic [DW-1:0] neg_exp;
        int waits;

        lit_a = '{13'h0050, 13'h0070, 13'h00D0, 13'h00F0};
`ifdef MAX_POOL_RELU_EN
        neg_exp = 13'h0000;
`else
        neg_exp = 13'h1FF8;
`endif
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Ascending ramp at full rate.
        for (int i = 0; i < int'(NPIX); i++) px[i] = DW'(i * 16);
        run_frame(px, 0, 0, -1, 1'b1);
        for (int k = 0; k < 4 && k < got_q.size(); k++)
            chk(got_q[k] == lit_a[k], "ramp_literal", 32'(got_q[k]), 32'(lit_a[k]));

        // Mixed-sign and all-negative windows.
        for (int i = 0; i < int'(NPIX); i++) px[i] = rand_pix();
        px[0] = 13'h0010; px[1] = 13'h1FF0; px[4] = 13'h0020; px[5] = 13'h0005;
        px[2] = 13'h1FF0; px[3] = 13'h1FE0; px[6] = 13'h1F00; px[7] = 13'h1FF8;
        run_frame(px, 0, 0, -1, 1'b1);
        if (got_q.size() >= 2) begin
            chk(got_q[0] == 13'h0020, "mixed_literal", 32'(got_q[0]), 32'h0020);
            chk(got_q[1] == neg_exp, "neg_literal", 32'(got_q[1]), 32'(neg_exp));
        end

        // Ramp with 10-cycle output stall after first out_valid.
        for (int i = 0; i < int'(NPIX); i++) px[i] = DW'(i * 16);
        run_frame(px, 0, 2, -1, 1'b0);
        chk(stall_cycles == 10, "stall_cycles", 32'(stall_cycles), 10);
        for (int k = 0; k < 4 && k < got_q.size(); k++)
            chk(got_q[k] == lit_a[k], "stall_literal", 32'(got_q[k]), 32'(lit_a[k]));

        // start pulsed mid-frame must be ignored.
        for (int i = 0; i < int'(NPIX); i++) px[i] = rand_pix();
        run_frame(px, 2, 1, 7, 1'b0);

        // Reset mid-frame with a pooled pixel pending.
        for (int i = 0; i < int'(NPIX); i++) px[i] = rand_pix();
        start_frame(px, 3);
        for (int i = 0; i < 6; i++) send_pixel(px[i], 0, waits);
        step();
        chk(bus.out_valid == 1'b1, "pre_reset_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        rdy_mode = 0;
        repeat (2) step();
        chk(done_cnt == 0, "midreset_no_done", 32'(done_cnt), 0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < int'(NPIX); i++) px[i] = rand_pix();
        run_frame(px, 0, 0, -1, 1'b1);

        // Randomized frames: random gaps and back-pressure.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < int'(NPIX); i++) px[i] = rand_pix();
            run_frame(px, (f % 3), (f % 2 == 0) ? 1 : 0, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
